// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory stage: access sizes, write-back control
// bit positions and the bus FSM states.
package mips_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int WBI_REGWRITE = 1;
    localparam int WBI_MEMTOREG = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Size encoding 2'b11 is handled like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: replicates store data across the bus with byte
// enables, and pulls the addressed byte/halfword out of read data with sign extension.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rbyte
            assign rbyte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rbyte[addr_lo];
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                be        = 4'b0001 << addr_lo;
                load_data = {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                wdata     = {2{store_data[15:0]}};
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{sel_half[15]}}, sel_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// MIPS memory stage: req/ack data-bus master with stall and timeout, lane
// steering, and the MEM/WB pipeline register.
module stage_mem
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              nop_in,
    input  logic [1:0]        wbi,
    input  logic              M,
    input  logic [1:0]        memdatasize,
    input  logic [4:0]        regaddr,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       data_b,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic [31:0]       fwd_data,
    output logic              wb_regwrite,
    output logic [4:0]        wb_regaddr,
    output logic [31:0]       wb_result,
    output logic              wb_nop,
    output logic              align_err,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    mem_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [ADDR_W-1:0] cap_addr_reg;
    logic [1:0]        cap_size_reg;
    logic              cap_we_reg;
    logic [31:0]       cap_data_reg;
    logic [4:0]        cap_regaddr_reg;
    logic [1:0]        cap_wbi_reg;

    logic              in_wait, access, live_mis, timed_out, req_raw, done, is_load;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size, sel_wbi;
    logic              sel_we;
    logic [31:0]       sel_data;
    logic [4:0]        sel_regaddr;
    logic [31:0]       lane_wdata, lane_load;
    logic [3:0]        lane_be;

    logic              wb_nop_next, wb_regwrite_next;
    logic [4:0]        wb_regaddr_next;
    logic [31:0]       wb_result_next;

    assign in_wait   = (state_reg == ST_WAIT);
    assign access    = !nop_in && (M || wbi[WBI_MEMTOREG]);
    assign live_mis  = is_misaligned(memdatasize, alu_out[1:0]);
    assign timed_out = in_wait && (TIMEOUT != 0) && (cnt_reg == CNT_LIMIT);

    // While waiting, the bus and the completing instruction come only from the captured copy.
    assign sel_addr    = in_wait ? cap_addr_reg    : alu_out[ADDR_W-1:0];
    assign sel_size    = in_wait ? cap_size_reg    : memdatasize;
    assign sel_we      = in_wait ? cap_we_reg      : M;
    assign sel_data    = in_wait ? cap_data_reg    : data_b;
    assign sel_regaddr = in_wait ? cap_regaddr_reg : regaddr;
    assign sel_wbi     = in_wait ? cap_wbi_reg     : wbi;

    mem_lane_align u_lane_align (
        .size       (sel_size),
        .addr_lo    (sel_addr[1:0]),
        .store_data (sel_data),
        .rdata      (dmem_rdata),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .load_data  (lane_load)
    );

    // The timeout cycle itself drops req, so a late ack there is never seen.
    assign req_raw    = in_wait ? !timed_out : (access && !live_mis);
    assign dmem_req   = req_raw && !reset;
    assign dmem_we    = sel_we;
    assign dmem_be    = lane_be;
    assign dmem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = lane_wdata;
    assign mem_stall  = dmem_req && !dmem_ack;
    assign done       = dmem_req && dmem_ack;
    assign is_load    = sel_wbi[WBI_MEMTOREG] && !sel_we;
    assign fwd_data   = wb_result;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        wb_nop_next      = 1'b1;
        wb_regwrite_next = 1'b0;
        wb_regaddr_next  = '0;
        wb_result_next   = '0;

        case (state_reg)
            ST_IDLE: begin
                if (mem_stall) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (done || timed_out) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (done) begin
            wb_nop_next      = 1'b0;
            wb_regwrite_next = sel_wbi[WBI_REGWRITE];
            wb_regaddr_next  = sel_regaddr;
            wb_result_next   = is_load ? lane_load : alu_out_or_cap();
        end else if (!in_wait && !nop_in && !access) begin
            wb_nop_next      = 1'b0;
            wb_regwrite_next = wbi[WBI_REGWRITE];
            wb_regaddr_next  = regaddr;
            wb_result_next   = alu_out;
        end
    end

    // A store/non-load completing from WAIT reports its captured address as its result.
    function automatic logic [31:0] alu_out_or_cap();
        logic [31:0] r;
        r = alu_out;
        if (in_wait) begin
            r = '0;
            r[ADDR_W-1:0] = cap_addr_reg;
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            wb_nop      <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_regaddr  <= '0;
            wb_result   <= '0;
            align_err   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wb_nop      <= wb_nop_next;
            wb_regwrite <= wb_regwrite_next;
            wb_regaddr  <= wb_regaddr_next;
            wb_result   <= wb_result_next;
            align_err   <= !in_wait && access && live_mis;
            bus_err     <= timed_out;
        end
    end

    always_ff @(posedge clock) begin
        if (!in_wait && mem_stall) begin
            cap_addr_reg    <= alu_out[ADDR_W-1:0];
            cap_size_reg    <= memdatasize;
            cap_we_reg      <= M;
            cap_data_reg    <= data_b;
            cap_regaddr_reg <= regaddr;
            cap_wbi_reg     <= wbi;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized self-checking bench for stage_mem against an instruction-level
// reference model (lane rules, sign extension, ack delay and timeout budget).
module tb_stage_mem;

    localparam int TMO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        nop_in;
    logic [1:0]  wbi;
    logic        M;
    logic [1:0]  memdatasize;
    logic [4:0]  regaddr;
    logic [31:0] alu_out, data_b;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack, mem_stall;
    logic [31:0] fwd_data, wb_result;
    logic        wb_regwrite, wb_nop, align_err, bus_err;
    logic [4:0]  wb_regaddr;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    stage_mem #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .nop_in(nop_in), .wbi(wbi), .M(M),
        .memdatasize(memdatasize), .regaddr(regaddr), .alu_out(alu_out), .data_b(data_b),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .fwd_data(fwd_data), .wb_regwrite(wb_regwrite),
        .wb_regaddr(wb_regaddr), .wb_result(wb_result), .wb_nop(wb_nop),
        .align_err(align_err), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input int sz, input int a);
        if (sz == 2) return 4'(1 << a);
        if (sz == 1) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] b);
        if (sz == 2) return {24'h0, b[7:0]} * 32'h0101_0101;
        if (sz == 1) return {16'h0, b[15:0]} * 32'h0001_0001;
        return b;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input int a, input logic [31:0] rd);
        int v;
        if (sz == 2) begin
            v = int'((rd >> (8 * a)) & 32'hFF);
            if (v >= 128) v -= 256;
            return 32'(v);
        end
        if (sz == 1) begin
            v = int'((rd >> (16 * (a / 2))) & 32'hFFFF);
            if (v >= 32768) v -= 65536;
            return 32'(v);
        end
        return rd;
    endfunction

    function automatic bit m_mis(input int sz, input int a);
        if (sz == 2) return 1'b0;
        if (sz == 1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    // Apply one instruction right after a rising edge and follow it to write-back.
    // delay = cycles after issue before ack (>= TMO means the bus never answers in time).
    task automatic run_instr(input bit nop, input bit rw, input bit ml, input bit st,
                             input int sz, input logic [4:0] rd, input logic [31:0] addr,
                             input logic [31:0] b, input logic [31:0] rdat, input int delay);
        bit acc, mis, ld, fin;
        int a, cyc, stalls;
        logic [31:0] exp_res;
        nop_in = nop; wbi = {rw, ml}; M = st; memdatasize = 2'(sz);
        regaddr = rd; alu_out = addr; data_b = b; dmem_ack = 1'b0; dmem_rdata = $urandom;
        a      = int'(addr[1:0]);
        acc    = !nop && (st || ml);
        mis    = acc && m_mis(sz, a);
        ld     = ml && !st;
        stalls = 0;
        txn++;
        if (!acc || mis) begin
            @(negedge clock);
            check("req_idle", dmem_req, 0);
            check("stall_idle", mem_stall, 0);
            @(posedge clock); #1;
            if (!acc && !nop) begin
                check("pt_nop", wb_nop, 0);
                check("pt_regwrite", wb_regwrite, rw);
                check("pt_regaddr", wb_regaddr, rd);
                check("pt_result", wb_result, addr);
                check("pt_fwd", fwd_data, addr);
            end else begin
                check("bub_nop", wb_nop, 1);
                check("bub_regwrite", wb_regwrite, 0);
                check("bub_result", wb_result, 0);
            end
            check("align_err", align_err, mis);
            check("bus_err_idle", bus_err, 0);
        end else begin
            cyc = 0;
            fin = 0;
            exp_res = ld ? m_load(sz, a, rdat) : addr;
            while (!fin) begin
                if (cyc > 0) begin
                    alu_out = $urandom; data_b = $urandom;
                    regaddr = 5'($urandom); memdatasize = 2'($urandom);
                end
                dmem_ack   = (cyc == delay);
                dmem_rdata = (cyc == delay) ? rdat : $urandom;
                @(negedge clock);
                if (cyc < TMO) begin
                    check("req", dmem_req, 1);
                    check("we", dmem_we, st);
                    check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
                    if (st) begin
                        check("be", dmem_be, m_be(sz, a));
                        check("wdata", dmem_wdata, m_wdata(sz, b));
                    end
                    check("stall", mem_stall, cyc != delay);
                    if (cyc != delay) stalls++;
                end else begin
                    check("req_tmo", dmem_req, 0);
                    check("stall_tmo", mem_stall, 0);
                end
                @(posedge clock); #1;
                if (cyc == delay && cyc < TMO) begin
                    check("done_nop", wb_nop, 0);
                    check("done_regwrite", wb_regwrite, rw);
                    check("done_regaddr", wb_regaddr, rd);
                    check("done_result", wb_result, exp_res);
                    check("done_fwd", fwd_data, exp_res);
                    check("done_bus_err", bus_err, 0);
                    check("done_align_err", align_err, 0);
                    fin = 1;
                end else if (cyc == TMO) begin
                    check("tmo_bus_err", bus_err, 1);
                    check("tmo_nop", wb_nop, 1);
                    check("tmo_regwrite", wb_regwrite, 0);
                    fin = 1;
                end else begin
                    check("wait_nop", wb_nop, 1);
                    check("wait_result", wb_result, 0);
                    check("wait_bus_err", bus_err, 0);
                end
                cyc++;
            end
            dmem_ack = 1'b0;
        end
        $display("txn %0d nop=%0d rw=%0d ml=%0d st=%0d sz=%0d addr=%h delay=%0d stalls=%0d",
                 txn, nop, rw, ml, st, sz, addr, delay, stalls);
    endtask

    initial begin
        int kind, r, sz, dly;
        bit nop, ml, st;
        // Reset with a store presented: req must stay gated.
        reset = 1'b1; nop_in = 1'b0; wbi = 2'b00; M = 1'b1; memdatasize = 2'b00;
        regaddr = 5'd3; alu_out = 32'h100; data_b = 32'h55; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb_nop", wb_nop, 1);
        check("rst_regwrite", wb_regwrite, 0);
        check("rst_regaddr", wb_regaddr, 0);
        check("rst_result", wb_result, 0);
        check("rst_align", align_err, 0);
        check("rst_bus", bus_err, 0);
        reset = 1'b0;

        run_instr(0, 0, 0, 1, 0, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0);       // sw, zero wait
        run_instr(0, 1, 1, 0, 2, 5'd7, 32'h103, 32'h0, 32'h80FFFFFF, 2);       // lb, 2 waits
        run_instr(0, 0, 0, 1, 1, 5'd0, 32'h101, 32'h1234, 32'h0, 0);           // sh misaligned
        run_instr(0, 0, 0, 1, 1, 5'd0, 32'h102, 32'h1234, 32'h0, 0);           // sh aligned
        run_instr(0, 1, 1, 0, 0, 5'd9, 32'h200, 32'h0, 32'h12345678, TMO);     // lw, late ack
        run_instr(0, 1, 0, 0, 0, 5'd5, 32'h2A, 32'h0, 32'h0, 0);               // add pass-through

        // Reset while waiting abandons the access.
        nop_in = 1'b0; wbi = 2'b11; M = 1'b0; memdatasize = 2'b00;
        regaddr = 5'd4; alu_out = 32'h300; dmem_ack = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rstw_req", dmem_req, 0);
        check("rstw_stall", mem_stall, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rstw_wb_nop", wb_nop, 1);
        check("rstw_regwrite", wb_regwrite, 0);
        run_instr(0, 1, 1, 0, 0, 5'd4, 32'h300, 32'h0, 32'hCAFEF00D, 1);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            nop  = (kind == 0);
            st   = (kind >= 7) || (nop && $urandom_range(0, 1) == 1);
            ml   = (kind >= 4 && kind <= 6) || (st && $urandom_range(0, 1) == 1);
            sz   = $urandom_range(0, 3);
            r    = $urandom_range(0, 19);
            dly  = (r < 15) ? (r % 4) : ((r < 17) ? TMO : TMO + 5);
            run_instr(nop, 1'($urandom), ml, st, sz, 5'($urandom), $urandom, $urandom,
                      $urandom, dly);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
